// File: rtl/reg_dump_if.sv
// Register dump bus: start/range request, register-file read port,
// valid/ready dump stream and status.
interface reg_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Start;
  logic [ADDR_W-1:0] FirstAddr;
  logic [ADDR_W-1:0] LastAddr;
  logic [ADDR_W-1:0] AddrA;
  logic [DATA_W-1:0] DataA;
  logic              DumpValid;
  logic              DumpReady;
  logic [ADDR_W-1:0] DumpAddr;
  logic [DATA_W-1:0] DumpData;
  logic              Busy;
  logic              Done;

  modport master (
    output Start,
    output FirstAddr,
    output LastAddr,
    input  AddrA,
    output DataA,
    input  DumpValid,
    output DumpReady,
    input  DumpAddr,
    input  DumpData,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  FirstAddr,
    input  LastAddr,
    output AddrA,
    input  DataA,
    output DumpValid,
    input  DumpReady,
    output DumpAddr,
    output DumpData,
    output Busy,
    output Done
  );
endinterface

// File: rtl/reg_dump.sv
// Streams a wrapping register range out over a valid/ready port.
// Define REG_DUMP_SKIP_X0_EN to read-skip register 0 inside the range.
module reg_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic   CLK,
  input  logic   RSTn,
  reg_dump_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              valid;
  logic              done;

  logic is_idle;
  logic is_read;
  logic is_flush;
  logic xfer;
  logic load;
  logic at_last;
  logic skip;

  assign is_idle  = (state == IDLE);
  assign is_read  = (state == READ);
  assign is_flush = (state == FLUSH);

  assign xfer    = valid & bus.DumpReady;
  assign load    = ~valid | xfer;
  assign at_last = (ptr == last_q);

`ifdef REG_DUMP_SKIP_X0_EN
  assign skip = (ptr == '0);
`else
  assign skip = 1'b0;
`endif

  // A skipped x0 consumes a load slot but captures nothing.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      ptr       <= '0;
      last_q    <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        is_idle: begin
          if (bus.Start) begin
            last_q <= bus.LastAddr;
            ptr    <= bus.FirstAddr;
            state  <= READ;
          end
        end
        is_read: begin
          if (load) begin
            ptr <= ptr + ONE;
            if (skip) begin
              valid <= 1'b0;
            end else begin
              valid     <= 1'b1;
              dump_addr <= ptr;
              dump_data <= bus.DataA;
            end
            if (at_last) begin
              if (skip) begin
                ptr   <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        is_flush: begin
          if (xfer) begin
            valid <= 1'b0;
            ptr   <= '0;
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          valid <= 1'b0;
          ptr   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.AddrA     = ptr;
  assign bus.DumpValid = valid;
  assign bus.DumpAddr  = dump_addr;
  assign bus.DumpData  = dump_data;
  assign bus.Busy      = ~is_idle;
  assign bus.Done      = done;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: randomized ranges and backpressure
// against a queue-based model of the expected beat stream.
module tb_reg_dump;

`ifdef REG_DUMP_SKIP_X0_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          n;
  } beat_t;

  logic clk;
  logic rstn;
  logic [31:0] rf [32];
  int vectors;
  int miscompares;

  reg_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK (clk),
    .RSTn(rstn),
    .bus (bus)
  );

  assign bus.DataA = rf[bus.AddrA];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic run_dump(input int first, input int last, input int hold,
                          input bit rnd, input bit restart, input string tag);
    beat_t q[$];
    beat_t b;
    int a, idx, n, done_n;
    bit stall;
    logic [4:0] pa, paa;
    logic [31:0] pd;
    a = first;
    idx = 0;
    forever begin
      if (!(SKIP && a == 0)) begin
        b.addr = a;
        b.data = rf[a];
        b.n = idx + 2;
        q.push_back(b);
      end
      if (a == last) break;
      a = (a + 1) % 32;
      idx++;
    end
    done_n = (q.size() == 0) ? 2 : -1;
    bus.FirstAddr = 5'(first);
    bus.LastAddr = 5'(last);
    bus.Start = 1'b1;
    stall = 1'b0;
    pa = '0;
    paa = '0;
    pd = '0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.Start = 1'b0;
      if (restart && n == 3) begin
        bus.Start = 1'b1;
        bus.FirstAddr = 5'($urandom);
        bus.LastAddr = 5'($urandom);
      end
      if (restart && n == 4) bus.Start = 1'b0;
      bus.DumpReady = (n <= hold) ? 1'b0 :
                      (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      vectors++;
      if (bus.Done !== (n == done_n)) begin
        miscompares++;
        $display("FAIL %s done n=%0d got %b want %b", tag, n, bus.Done,
                 (n == done_n));
      end
      vectors++;
      if (bus.Busy !== (n != done_n)) begin
        miscompares++;
        $display("FAIL %s busy n=%0d got %b want %b", tag, n, bus.Busy,
                 (n != done_n));
      end
      if (stall) begin
        vectors++;
        if (bus.DumpValid !== 1'b1 || bus.DumpAddr !== pa ||
            bus.DumpData !== pd || bus.AddrA !== paa) begin
          miscompares++;
          $display("FAIL %s hold n=%0d got v=%b a=%0d d=%h ra=%0d want v=1 a=%0d d=%h ra=%0d",
                   tag, n, bus.DumpValid, bus.DumpAddr, bus.DumpData,
                   bus.AddrA, pa, pd, paa);
        end
      end
      if (bus.DumpValid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra beat n=%0d got a=%0d want none", tag, n,
                   bus.DumpAddr);
        end else begin
          if (bus.DumpAddr !== 5'(q[0].addr) ||
              bus.DumpData !== q[0].data) begin
            miscompares++;
            $display("FAIL %s beat n=%0d got a=%0d d=%h want a=%0d d=%h",
                     tag, n, bus.DumpAddr, bus.DumpData, q[0].addr,
                     q[0].data);
          end
          if (!rnd && hold == 0) begin
            vectors++;
            if (n != q[0].n) begin
              miscompares++;
              $display("FAIL %s timing a=%0d got n=%0d want n=%0d", tag,
                       q[0].addr, n, q[0].n);
            end
          end
          if (bus.DumpReady) begin
            void'(q.pop_front());
            if (q.size() == 0) done_n = n + 1;
          end
        end
      end
      stall = bus.DumpValid && !bus.DumpReady;
      pa = bus.DumpAddr;
      pd = bus.DumpData;
      paa = bus.AddrA;
      if (n == done_n) break;
      if (n > 600) begin
        miscompares++;
        $display("FAIL %s timeout got %0d beats left want 0", tag, q.size());
        break;
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.Done !== 1'b0 || bus.DumpValid !== 1'b0 || bus.Busy !== 1'b0
        || bus.AddrA !== 5'd0) begin
      miscompares++;
      $display("FAIL %s idle got d=%b v=%b b=%b ra=%0d want 0 0 0 0", tag,
               bus.Done, bus.DumpValid, bus.Busy, bus.AddrA);
    end
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (bus.AddrA !== 5'd0 || bus.DumpValid !== 1'b0 ||
        bus.DumpAddr !== 5'd0 || bus.DumpData !== 32'd0 ||
        bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got ra=%0d v=%b a=%0d d=%h b=%b dn=%b want all 0",
               tag, bus.AddrA, bus.DumpValid, bus.DumpAddr, bus.DumpData,
               bus.Busy, bus.Done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.Start = 1'b0;
    bus.FirstAddr = '0;
    bus.LastAddr = '0;
    bus.DumpReady = 1'b1;
    preload();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
  endtask

  task automatic test_basic();
    preload();
    run_dump(4, 7, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    preload();
    run_dump(30, 1, 0, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_backpressure();
    preload();
    run_dump(9, 9, 6, 1'b0, 1'b0, "bp");
  endtask

  task automatic test_stale();
    int n;
    preload();
    bus.DumpReady = 1'b0;
    bus.FirstAddr = 5'd5;
    bus.LastAddr = 5'd5;
    bus.Start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.Start = 1'b0;
      n++;
    end while (bus.DumpValid !== 1'b1 && n < 20);
    rf[5] = 32'hDEADBEEF;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (bus.DumpValid !== 1'b1 || bus.DumpAddr !== 5'd5 ||
          bus.DumpData !== 32'd15) begin
        miscompares++;
        $display("FAIL stale got v=%b a=%0d d=%h want v=1 a=5 d=f",
                 bus.DumpValid, bus.DumpAddr, bus.DumpData);
      end
    end
    bus.DumpReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_done got done=%b busy=%b want 1 0", bus.Done,
               bus.Busy);
    end
    rf[5] = 32'd15;
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    preload();
    run_dump(10, 25, 0, 1'b0, 1'b1, "start_busy");
    rand_rf();
    run_dump(20, 12, 0, 1'b1, 1'b1, "start_busy_rnd");
  endtask

  task automatic test_only_x0();
    preload();
    run_dump(0, 0, 0, 1'b0, 1'b0, "only_x0");
  endtask

  task automatic test_full();
    int f;
    rand_rf();
    f = $urandom_range(0, 31);
    run_dump(f, (f + 31) % 32, 0, 1'b0, 1'b0, "full");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      rand_rf();
      run_dump($urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 3), 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    int n, cnt;
    preload();
    bus.DumpReady = 1'b1;
    bus.FirstAddr = 5'd0;
    bus.LastAddr = 5'd7;
    bus.Start = 1'b1;
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 50) begin
      @(negedge clk);
      bus.Start = 1'b0;
      n++;
      if (bus.DumpValid === 1'b1 && bus.DumpReady) cnt++;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("reset_mid");
    @(posedge clk);
    #1;
    check_zero("reset_mid_hold");
    @(negedge clk);
    check_zero("reset_mid_nodone");
    rstn = 1'b1;
    run_dump(0, 31, 0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_stale();
    test_start_busy();
    test_only_x0();
    test_full();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port FirstAddr  input  ADDR_W  first register of range, latched on accepted Start.
REQ-007 SHALL have port LastAddr  input  ADDR_W  last register of range (inclusive), latched on accepted Start.
REQ-008 SHALL have port AddrA  output  ADDR_W  read address to register file port A.
REQ-009 SHALL have port DataA  input  DATA_W  combinational read data from register file port A.
REQ-010 SHALL have port DumpValid  output  1  output beat valid.
REQ-011 SHALL have port DumpReady  input  1  consumer ready; beat transfers when DumpValid and DumpReady both high at a rising edge.
REQ-012 SHALL have port DumpAddr  output  ADDR_W  register index of current beat.
REQ-013 SHALL have port DumpData  output  DATA_W  register value of current beat.
REQ-014 SHALL have port Busy  output  1  high from accepted Start until Done.
REQ-015 SHALL have port Done  output  1  one-cycle pulse after final beat transfers.

Function
REQ-016 SHALL implement states IDLE, READ, FLUSH.
REQ-017 IDLE: Start=1 at an edge SHALL latch FirstAddr/LastAddr, set read pointer to FirstAddr, enter READ, raise Busy.
REQ-018 Start while Busy=1 SHALL be ignored.
REQ-019 Range SHALL wrap modulo 2^ADDR_W: beat count = ((LastAddr - FirstAddr) mod 32) + 1; FirstAddr==LastAddr gives 1 beat; FirstAddr=LastAddr+1 gives all 32.
REQ-020 AddrA SHALL equal the read pointer at all times (0 in IDLE).
REQ-021 One-entry output register: in READ, when DumpValid=0 or a beat transfers, SHALL capture DataA and AddrA into DumpData/DumpAddr, set DumpValid=1, advance pointer by 1 mod 32.
REQ-022 First DumpValid SHALL rise one cycle after READ entry; sustained throughput one beat per cycle while DumpReady=1.
REQ-023 DumpValid=1 and DumpReady=0 SHALL hold DumpAddr, DumpData, AddrA stable.
REQ-024 Captured value SHALL be DataA at the capture edge; register-file writes after capture SHALL NOT alter a held beat.
REQ-025 After capturing the LastAddr beat, SHALL enter FLUSH; FLUSH exits to IDLE at the edge the final beat transfers.
REQ-026 Done SHALL pulse for exactly the cycle after final transfer; Busy SHALL fall in the same cycle Done is high.
REQ-027 DumpValid SHALL never be high in IDLE.

Reset
REQ-028 RSTn=0 SHALL immediately force IDLE, AddrA=0, DumpValid=0, DumpAddr=0, DumpData=0, Busy=0, Done=0, pointer=0.
REQ-029 Reset mid-dump SHALL abandon the dump with no Done pulse; a new Start is accepted at the first edge after RSTn rises.

Configuration
REQ-030 Macro REG_DUMP_SKIP_X0_EN defined: address 0 inside the range SHALL be read-skipped (pointer passes it with no beat, costing one cycle); a range containing only x0 SHALL produce zero beats, then Done one cycle after READ entry.
REQ-031 Macro REG_DUMP_SKIP_X0_EN undefined: address 0 SHALL be dumped like any other register.

Verification
REQ-032 Registers preloaded x[i]=i*3; Start First=4 Last=7, DumpReady=1 -> beats (4,12),(5,15),(6,18),(7,21) on consecutive cycles, first 1 cycle after READ entry, then Done pulse.
REQ-033 First=30 Last=1 -> beats addresses 30,31,0,1 in order (x0 omitted when REG_DUMP_SKIP_X0_EN defined: 30,31,1).
REQ-034 First=Last=9, DumpReady held 0 for 5 cycles -> DumpValid held with DumpAddr=9 stable; one beat on release; Done follows.
REQ-035 Write x5=0xDEADBEEF while beat addr 5 (old value 15) held under backpressure -> DumpData stays 15.
REQ-036 RSTn pulsed low after 2 of 8 beats -> outputs zero immediately, no Done; new Start First=0 Last=31 yields 32 beats (31 with skip macro).
REQ-037 Start asserted again while Busy -> ignored; range and beat sequence unchanged.
